// File: rtl/traffic_cycle_sched.sv
// traffic_cycle_sched: cycle scheduler and phase timer for the two-road light FSM.
// Latches road demand, starts a light cycle through an enable/enable_sig handshake,
// produces the prescaled 5-bit phase count (counter_24), and holds an all-red gap
// between cycles.
// Optional watchdog: define TRAFFIC_SCHED_WDOG_EN to add the sticky 'fault' output,
// which blocks new cycles once the phase count overruns at 31.
module traffic_cycle_sched #(
  parameter int TICK_DIV   = 4,
  parameter int DIV_W      = 16,
  parameter int GAP_CYCLES = 8,
  parameter int GAP_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       auto_mode,
  input  logic       sense1,
  input  logic       sense2,
  input  logic       hold,
  input  logic       enable_sig,
  output logic       enable,
  output logic [4:0] counter_24,
  output logic       tick,
  output logic       pending1,
  output logic       pending2,
  output logic       cycle_done,
  output logic       served1,
  output logic       served2
`ifdef TRAFFIC_SCHED_WDOG_EN
  ,
  output logic       fault
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam bit               NO_GAP   = (GAP_CYCLES == 0);

  state_t           state_q, state_d;
  logic             enable_q, enable_d;
  logic [4:0]       counter_q, counter_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             pending1_q, pending1_d;
  logic             pending2_q, pending2_d;
  logic             snap1_q, snap1_d;
  logic             snap2_q, snap2_d;
  logic             cycle_done_q, cycle_done_d;
  logic             served1_q, served1_d;
  logic             served2_q, served2_d;
  logic             complete;
  logic             start_ok;
  logic             tick_w;

  // Terminal count of the prescaler: only while the light FSM is busy in RUN and not held.
  assign tick_w = (state_q == S_RUN) & enable_sig & ~hold & (div_q == DIV_LAST);

`ifdef TRAFFIC_SCHED_WDOG_EN
  logic fault_q, fault_d;

  // Overrun watchdog: a tick arriving with the count already saturated means the
  // light FSM never finished; the flag is sticky until reset.
  always_comb begin
    fault_d = fault_q | (tick_w & (counter_q == 5'd31));
  end

  // Watchdog flag register.
  always_ff @(posedge clk) begin
    if (rst) fault_q <= 1'b0;
    else     fault_q <= fault_d;
  end

  assign start_ok = ~fault_q;
  assign fault    = fault_q;
`else
  assign start_ok = 1'b1;
`endif

  // Next-state logic for the cycle FSM, phase timer, gap timer and completion pulses.
  always_comb begin
    state_d      = state_q;
    enable_d     = enable_q;
    counter_d    = 5'd0;
    div_d        = '0;
    gap_d        = '0;
    snap1_d      = snap1_q;
    snap2_d      = snap2_q;
    cycle_done_d = 1'b0;
    served1_d    = 1'b0;
    served2_d    = 1'b0;
    complete     = 1'b0;

    case (state_q)
      S_IDLE: begin
        enable_d = 1'b0;
        if (start_ok && (auto_mode || pending1_q || pending2_q)) begin
          enable_d = 1'b1;
          state_d  = S_START;
        end
      end

      S_START: begin
        // Hold the request until the light FSM reports busy; no timeout by design.
        if (enable_sig) begin
          snap1_d  = pending1_q;
          snap2_d  = pending2_q;
          enable_d = 1'b0;
          state_d  = S_RUN;
        end
      end

      S_RUN: begin
        enable_d = 1'b0;
        if (!enable_sig) begin
          // Light FSM dropped busy: report which demands this cycle served.
          complete     = 1'b1;
          cycle_done_d = 1'b1;
          served1_d    = snap1_q;
          served2_d    = snap2_q;
          snap1_d      = 1'b0;
          snap2_d      = 1'b0;
          state_d      = NO_GAP ? S_IDLE : S_GAP;
        end else begin
          counter_d = counter_q;
          div_d     = div_q;
          if (!hold) begin
            if (tick_w) begin
              div_d = '0;
              if (counter_q != 5'd31) counter_d = counter_q + 5'd1;
            end else begin
              div_d = div_q + DIV_W'(1);
            end
          end
        end
      end

      S_GAP: begin
        enable_d = 1'b0;
        if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      default: begin
        enable_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  // Demand latches: new demand always wins over the clear of a served demand.
  always_comb begin
    pending1_d = sense1 | (pending1_q & ~(complete & snap1_q));
    pending2_d = sense2 | (pending2_q & ~(complete & snap2_q));
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      enable_q     <= 1'b0;
      counter_q    <= 5'd0;
      div_q        <= '0;
      gap_q        <= '0;
      pending1_q   <= 1'b0;
      pending2_q   <= 1'b0;
      snap1_q      <= 1'b0;
      snap2_q      <= 1'b0;
      cycle_done_q <= 1'b0;
      served1_q    <= 1'b0;
      served2_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      enable_q     <= enable_d;
      counter_q    <= counter_d;
      div_q        <= div_d;
      gap_q        <= gap_d;
      pending1_q   <= pending1_d;
      pending2_q   <= pending2_d;
      snap1_q      <= snap1_d;
      snap2_q      <= snap2_d;
      cycle_done_q <= cycle_done_d;
      served1_q    <= served1_d;
      served2_q    <= served2_d;
    end
  end

  assign enable     = enable_q;
  assign counter_24 = counter_q;
  assign tick       = tick_w;
  assign pending1   = pending1_q;
  assign pending2   = pending2_q;
  assign cycle_done = cycle_done_q;
  assign served1    = served1_q;
  assign served2    = served2_q;

endmodule

// File: tb/tb_traffic_cycle_sched.sv
// Self-checking bench for traffic_cycle_sched (TICK_DIV=2, GAP_CYCLES=3).
// A small light-FSM model echoes enable into enable_sig one clock later and drops
// it when counter_24 reaches 27.
module tb_traffic_cycle_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       auto_mode = 1'b0;
  logic       sense1 = 1'b0;
  logic       sense2 = 1'b0;
  logic       hold = 1'b0;
  logic       enable_sig = 1'b0;
  logic       enable;
  logic [4:0] counter_24;
  logic       tick;
  logic       pending1, pending2;
  logic       cycle_done, served1, served2;
`ifdef TRAFFIC_SCHED_WDOG_EN
  logic       fault;
`endif

  logic drop_en   = 1'b1;
  logic force_low = 1'b0;

  int tests = 0;
  int fails = 0;

  traffic_cycle_sched #(
    .TICK_DIV(2), .DIV_W(16), .GAP_CYCLES(3), .GAP_W(8)
  ) dut (
    .clk(clk), .rst(rst), .auto_mode(auto_mode), .sense1(sense1), .sense2(sense2),
    .hold(hold), .enable_sig(enable_sig), .enable(enable), .counter_24(counter_24),
    .tick(tick), .pending1(pending1), .pending2(pending2), .cycle_done(cycle_done),
    .served1(served1), .served2(served2)
`ifdef TRAFFIC_SCHED_WDOG_EN
    , .fault(fault)
`endif
  );

  always #5 clk = ~clk;

  // Light FSM model.
  always @(posedge clk) begin
    if (rst || force_low)                  enable_sig <= 1'b0;
    else if (enable)                       enable_sig <= 1'b1;
    else if (drop_en && counter_24 == 5'd27) enable_sig <= 1'b0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst, s1, s2, hold;
    logic       en, p1, p2, tk, done;
    logic [4:0] cnt;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int n;
    int prev_cnt;
    bit found;

    // rst s1 s2 hold | enable p1 p2 tick done cnt
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1};
    vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd1};
    vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd2};

    // Reset, start handshake and first phase steps.
    for (int i = 0; i < 10; i++) begin
      rst    = vecs[i].rst;
      sense1 = vecs[i].s1;
      sense2 = vecs[i].s2;
      hold   = vecs[i].hold;
      step();
      check($sformatf("vec%0d_enable", i), enable, vecs[i].en);
      check($sformatf("vec%0d_pending1", i), pending1, vecs[i].p1);
      check($sformatf("vec%0d_pending2", i), pending2, vecs[i].p2);
      check($sformatf("vec%0d_tick", i), tick, vecs[i].tk);
      check($sformatf("vec%0d_cycle_done", i), cycle_done, vecs[i].done);
      check($sformatf("vec%0d_counter", i), counter_24, vecs[i].cnt);
      $display("[TB] vec %0d: enable=%0b p1=%0b p2=%0b tick=%0b cnt=%0d",
               i, enable, pending1, pending2, tick, counter_24);
    end
    sense2 = 1'b0;

    // Hold at counter_24 == 11 right after its tick (prescaler at 0).
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      if (counter_24 == 5'd11 && !tick) found = 1;
    end
    check("hold_reach_11", int'(found), 1);
    for (int i = 0; i < 10; i++) begin
      hold = 1'b1;
      step();
      check($sformatf("hold%0d_counter", i), counter_24, 11);
      check($sformatf("hold%0d_tick", i), tick, 0);
    end
    hold = 1'b0;
    step();
    check("release1_counter", counter_24, 11);
    check("release1_tick", tick, 1);
    step();
    check("release2_counter", counter_24, 12);
    $display("[TB] hold: counter held at 11, 12 two clocks after release");

    // Completion of the cycle that served road1; road2 demand stays pending.
    found = 0;
    prev_cnt = counter_24;
    for (int i = 0; i < 200 && !found; i++) begin
      prev_cnt = counter_24;
      step();
      if (cycle_done) found = 1;
    end
    check("done_seen", int'(found), 1);
    check("done_prev_counter", prev_cnt, 27);
    check("done_served1", served1, 1);
    check("done_served2", served2, 0);
    check("done_pending1", pending1, 0);
    check("done_pending2", pending2, 1);
    check("done_counter", counter_24, 0);
    $display("[TB] completion: served1=%0b served2=%0b p1=%0b p2=%0b",
             served1, served2, pending1, pending2);
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("gap%0d_enable", k), enable, (k == 4) ? 1 : 0);
      check($sformatf("gap%0d_cycle_done", k), cycle_done, 0);
      check($sformatf("gap%0d_served1", k), served1, 0);
    end
    $display("[TB] gap: enable returned 4 clocks after cycle_done");

    // Reset in the middle of the second cycle.
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (counter_24 == 5'd13) found = 1;
    end
    check("rst_reach_13", int'(found), 1);
    rst = 1'b1;
    step();
    check("rst_counter", counter_24, 0);
    check("rst_enable", enable, 0);
    check("rst_pending1", pending1, 0);
    check("rst_pending2", pending2, 0);
    check("rst_cycle_done", cycle_done, 0);
    check("rst_served2", served2, 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("post_rst%0d_done", i), cycle_done, 0);
      check($sformatf("post_rst%0d_enable", i), enable, 0);
    end
    $display("[TB] reset mid-run: cleared without completion pulses");

    // Overrun: the light FSM never drops busy; the count must saturate at 31.
    drop_en   = 1'b0;
    auto_mode = 1'b1;
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      step();
      if (counter_24 == 5'd31) found = 1;
    end
    check("sat_reach_31", int'(found), 1);
    for (int i = 0; i < 10; i++) step();
    check("sat_counter", counter_24, 31);
    check("sat_no_done", cycle_done, 0);
`ifdef TRAFFIC_SCHED_WDOG_EN
    check("wdog_fault_set", fault, 1);
`endif
    force_lo: begin
      force_low = 1'b1;
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
        step();
        if (cycle_done) found = 1;
      end
      force_low = 1'b0;
    end
    check("sat_done_seen", int'(found), 1);
    check("sat_done_counter", counter_24, 0);
`ifdef TRAFFIC_SCHED_WDOG_EN
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (enable) n++;
    end
    check("wdog_no_enable", n, 0);
    check("wdog_fault_sticky", fault, 1);
    rst = 1'b1;
    step();
    check("wdog_fault_cleared", fault, 0);
    rst = 1'b0;
    $display("[TB] watchdog: fault sticky, no restart until reset");
`else
    n = 0;
    for (int i = 0; i < 10 && !enable; i++) begin
      step();
      n++;
    end
    check("auto_restart_delay", n, 4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    $display("[TB] saturation: counter held at 31, auto restart after gap");
`endif
    auto_mode = 1'b0;
    drop_en   = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
